// File: rtl/rptr_empty_if.sv
// Read-side FIFO bus: read request and synchronized write pointer in,
// read address, Gray read pointer and registered status out.
interface rptr_empty_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rcount;
  logic                runderflow;

  // Handshake: a read is taken on any rclk edge where rinc=1 and the
  // registered rempty=0; rinc while empty is dropped and flagged as underflow.
  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rcount, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, raempty, rcount, runderflow
  );
endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer and status generator for a dual-clock FIFO: owns the
// read pointer (binary + Gray) and produces registered empty/almost-empty/count.
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input logic          rclk,
  input logic          rrst_n,
  rptr_empty_if.slave  bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_THR = PW'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rcount_q, rcount_d;
  logic [ADDRSIZE:0] wbin_s;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              runderflow_q, runderflow_d;
  logic              rd_ok;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(bus.rq2_wptr >> i);
    end
  end

  always_comb begin
    rd_ok        = bus.rinc & ~rempty_q;
    rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, rd_ok};
    rptr_d       = (rbin_d >> 1) ^ rbin_d;
    rcount_d     = wbin_s - rbin_d;
    // Comparing next-state pointers lets the last read raise empty on its own edge.
    rempty_d     = (rptr_d == bus.rq2_wptr);
    raempty_d    = (rcount_d <= AE_THR);
    runderflow_d = runderflow_q | (bus.rinc & rempty_q);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rcount_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rcount_q     <= rcount_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = raempty_q;
  assign bus.rcount     = rcount_q;
  assign bus.runderflow = runderflow_q;
endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: occupancy model built from integer read/write counts,
// checked every cycle, plus directed literal checks of the key scenarios.
module tb_rptr_empty;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int THR   = 2;
  localparam int MODW  = 32;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  rptr_empty_if #(.ADDRSIZE(AW)) bus ();

  rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(THR)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int w_bin  = 0;
  logic [PW-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  int   m_r     = 0;
  int   m_cnt   = 0;
  logic m_empty = 1'b1;
  logic m_uf    = 1'b0;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b % MODW);
    return v ^ (v >> 1);
  endfunction

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_r = 0; m_cnt = 0; m_empty = 1'b1; m_uf = 1'b0;
    end else begin
      if (bus.rinc && m_empty) m_uf = 1'b1;
      if (bus.rinc && !m_empty) m_r = (m_r + 1) % MODW;
      m_cnt   = (w_bin - m_r + MODW) % MODW;
      m_empty = (m_cnt == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge rclk) begin
    chk("raddr",      int'(bus.raddr),      m_r % DEPTH);
    chk("rptr",       int'(bus.rptr),       int'(to_gray(m_r)));
    chk("rempty",     int'(bus.rempty),     int'(m_empty));
    chk("raempty",    int'(bus.raempty),    int'(m_cnt <= THR));
    chk("rcount",     int'(bus.rcount),     m_cnt);
    chk("runderflow", int'(bus.runderflow), int'(m_uf));
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the next rise.
  task automatic tick(input bit rd, input int wadd);
    #1;
    bus.rinc     = rd;
    w_bin        = (w_bin + wadd) % MODW;
    bus.rq2_wptr = to_gray(w_bin);
    @(negedge rclk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rempty"},     int'(bus.rempty),     1);
    chk({tag, "_raempty"},    int'(bus.raempty),    1);
    chk({tag, "_rcount"},     int'(bus.rcount),     0);
    chk({tag, "_rptr"},       int'(bus.rptr),       0);
    chk({tag, "_raddr"},      int'(bus.raddr),      0);
    chk({tag, "_runderflow"}, int'(bus.runderflow), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.rinc     = 1'b1;
    bus.rq2_wptr = 5'b00011;
    repeat (3) @(negedge rclk);
    chk_reset_vals("reset");
    #1;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = '0;
    #1 rrst_n = 1'b1;
    @(negedge rclk);

    // Single word in, then read out.
    tick(0, 1);
    chk("single_rempty",  int'(bus.rempty),  0);
    chk("single_rcount",  int'(bus.rcount),  1);
    chk("single_raempty", int'(bus.raempty), 1);
    tick(1, 0);
    chk("single_rd_rempty", int'(bus.rempty), 1);
    chk("single_rd_rcount", int'(bus.rcount), 0);
    chk("single_rd_raddr",  int'(bus.raddr),  1);
    chk("single_rd_rptr",   int'(bus.rptr),   1);

    // Full FIFO then drain 16 back-to-back.
    tick(0, 16);
    chk("full_rcount",  int'(bus.rcount),  16);
    chk("full_raempty", int'(bus.raempty), 0);
    chk("full_rempty",  int'(bus.rempty),  0);
    for (int k = 15; k >= 0; k--) exp_q.push_back(PW'(k));
    for (int k = 0; k < 16; k++) begin
      logic [PW-1:0] e;
      tick(1, 0);
      e = exp_q.pop_front();
      chk("drain_rcount",  int'(bus.rcount),  int'(e));
      chk("drain_raempty", int'(bus.raempty), int'(e <= PW'(THR)));
      chk("drain_rempty",  int'(bus.rempty),  int'(e == 0));
    end

    // Wrap-around: one word resident, 40 simultaneous write/read pairs.
    tick(0, 1);
    for (int k = 0; k < 40; k++) begin
      tick(1, 1);
      chk("wrap_rcount", int'(bus.rcount), 1);
      chk("wrap_rempty", int'(bus.rempty), 0);
    end
    chk("wrap_raddr", int'(bus.raddr), 9);
    chk("wrap_rptr",  int'(bus.rptr),  5'b10101);

    // Drain, then underflow attempts.
    tick(1, 0);
    chk("uf_pre_rempty", int'(bus.rempty), 1);
    repeat (3) tick(1, 0);
    chk("uf_rptr",       int'(bus.rptr),       5'b10111);
    chk("uf_runderflow", int'(bus.runderflow), 1);

    // Randomized traffic: write-biased then read-biased phases.
    for (int k = 0; k < 3000; k++) begin
      bit rd;
      int wadd;
      if ((k / 500) % 2 == 0) begin
        rd   = ($urandom_range(0, 3) == 0);
        wadd = (m_cnt < DEPTH && $urandom_range(0, 3) != 0) ? 1 : 0;
      end else begin
        rd   = ($urandom_range(0, 3) != 0);
        wadd = (m_cnt < DEPTH && $urandom_range(0, 3) == 0) ? 1 : 0;
      end
      tick(rd, wadd);
    end
    chk("rand_runderflow_sticky", int'(bus.runderflow), 1);

    // Mid-operation asynchronous reset with five words resident.
    for (int k = 0; k < 20 && m_cnt > 0; k++) tick(1, 0);
    repeat (5) tick(0, 1);
    chk("pre_rst_rcount", int'(bus.rcount), 5);
    #3 rrst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    w_bin        = 0;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = '0;
    @(negedge rclk);
    #1 rrst_n = 1'b1;
    repeat (3) tick(0, 0);
    chk("post_rst_rempty", int'(bus.rempty), 1);
    chk("post_rst_rcount", int'(bus.rcount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
